// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage initiator between the MIPS datapath and a word-wide data
//   memory with no byte enables. One request is handled at a time; byte and
//   halfword stores are done as read-modify-write. Loads return sign- or
//   zero-extended data. Byte lanes are big-endian (offset 0 = bits [31:24]).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req               request strobe, sampled only while idle
//   we                1 = store, 0 = load
//   size              00 byte, 01 half, 10 word, 11 reserved
//   sign_ext          load extension select (1 = sign, 0 = zero)
//   addr, wdata       byte address, right-aligned store data
//   busy              high while an access is in progress (including FIN)
//   done, err         one-cycle completion pulse and its error flag
//   rdata             extended load result, held until the next completion
//   mem_addr          word index into memory
//   mem_wdata         word to write
//   mem_read          memory read enable (held RD_LAT cycles)
//   mem_write         memory write enable (held WR_LAT cycles)
//   mem_rdata         memory read data
module load_store_unit #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam int MAXL  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Request fields captured at acceptance
  logic               we_q;
  logic [1:0]         size_q;
  logic               sign_q;
  logic [1:0]         off_q;
  logic [15:0]        wdata_q;

  logic               bad;

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  off,
                                           input logic        sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the target lane of the fetched word with the store data.
  function automatic logic [31:0] rmw_merge(input logic [31:0] w,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  off,
                                            input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    m[31:24] = d[7:0];
        2'd1:    m[23:16] = d[7:0];
        2'd2:    m[15:8]  = d[7:0];
        default: m[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      m[15:0] = d;
    end else begin
      m[31:16] = d;
    end
    return m;
  endfunction

  always_comb begin
    bad = (size == 2'b11)
        | ((size == 2'b01) & addr[0])
        | ((size == 2'b10) & (addr[1:0] != 2'b00))
        | ({2'b00, addr[31:2]} >= 32'(DEPTH));
  end

  // Request capture: pure data, loaded only on acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_q    <= we;
      size_q  <= size;
      sign_q  <= sign_ext;
      off_q   <= addr[1:0];
      wdata_q <= wdata[15:0];
    end
  end

  // Control FSM with registered memory-side and CPU-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rdata     <= 32'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            err  <= bad;
            cnt  <= '0;
            if (bad) begin
              state <= FIN;
              done  <= 1'b1;
              rdata <= 32'h0;
            end else begin
              mem_addr <= {2'b00, addr[31:2]};
              if (we && size == 2'b10) begin
                state     <= WR;
                mem_write <= 1'b1;
                mem_wdata <= wdata;
              end else begin
                state    <= RD;
                mem_read <= 1'b1;
              end
            end
          end
        end

        RD: begin
          // mem_rdata is sampled on the last edge of the read window
          if (cnt == CNT_W'(RD_LAT - 1)) begin
            mem_read <= 1'b0;
            cnt      <= '0;
            if (we_q) begin
              state     <= WR;
              mem_write <= 1'b1;
              mem_wdata <= rmw_merge(mem_rdata, size_q, off_q, wdata_q);
            end else begin
              state <= FIN;
              done  <= 1'b1;
              rdata <= load_ext(mem_rdata, size_q, off_q, sign_q);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WR: begin
          if (cnt == CNT_W'(WR_LAT - 1)) begin
            mem_write <= 1'b0;
            cnt       <= '0;
            state     <= FIN;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  load_store_unit #(.DEPTH(1024), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural word memory; a single process owns the array.
  bit [31:0] mem [0:1023];
  logic       pre_we;
  logic [9:0] pre_idx;
  logic [31:0] pre_dat;

  always @(posedge clk) begin
    if (pre_we)         mem[pre_idx] <= pre_dat;
    else if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
  end

  assign mem_rdata = mem_read ? mem[mem_addr[9:0]] : 32'h5A5A_5A5A;

  int n_vec;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_dat = dat;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  // Per-transaction observations
  int          t_lat;
  int          t_rd;
  int          t_wr;
  int          t_both;
  int          t_addr_bad;
  int          t_wd_chg;
  int          t_busy_low;
  logic [31:0] t_first_addr;
  logic [31:0] t_wd;
  bit          t_done;

  // Called just after a negedge while the DUT is idle; returns at the
  // negedge of the idle cycle following FIN.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input bit noise);
    bit seen;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    t_lat = 0; t_rd = 0; t_wr = 0; t_both = 0; t_addr_bad = 0;
    t_wd_chg = 0; t_busy_low = 0; t_first_addr = '0; t_wd = '0; t_done = 0;
    seen = 0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      t_lat = k;
      if (!busy) t_busy_low++;
      if (mem_read) t_rd++;
      if (mem_write) begin
        if (t_wr > 0 && mem_wdata !== t_wd) t_wd_chg++;
        t_wr++;
        t_wd = mem_wdata;
      end
      if (mem_read && mem_write) t_both++;
      if (mem_read || mem_write) begin
        if (!seen) begin
          t_first_addr = mem_addr;
          seen = 1;
        end else if (mem_addr !== t_first_addr) begin
          t_addr_bad++;
        end
      end
      if (done) begin
        t_done = 1;
        req = 1'b0;
        break;
      end
      if (noise) begin
        req      = 1'($urandom_range(0, 1));
        we       = 1'($urandom_range(0, 1));
        size     = 2'($urandom_range(0, 3));
        sign_ext = 1'($urandom_range(0, 1));
        addr     = $urandom;
        wdata    = $urandom;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    chk("timeout", 32'(t_done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_txn(input string tag, input int lat, input int rd, input int wr,
                           input logic e, input logic [31:0] rd_data);
    chk({tag, "/lat"},   32'(t_lat), 32'(lat));
    chk({tag, "/rdcyc"}, 32'(t_rd),  32'(rd));
    chk({tag, "/wrcyc"}, 32'(t_wr),  32'(wr));
    chk({tag, "/err"},   32'(err),   32'(e));
    chk({tag, "/rdata"}, rdata,      rd_data);
    chk({tag, "/proto"}, 32'(t_both + t_addr_bad + t_wd_chg + t_busy_low), 32'd0);
  endtask

  int nd;
  int dpos [0:7];
  int idle_cnt;
  int wait_n;

  initial begin
    n_vec = 0; n_bad = 0;
    req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
    pre_we = 0; pre_idx = 0; pre_dat = 0;
    rst_n = 1'b0;

    preload(10'd4, 32'h8123_45F6);
    preload(10'd8, 32'h0A0B_0C0D);
    #1;
    chk("rst/busy",  32'(busy),      32'd0);
    chk("rst/done",  32'(done),      32'd0);
    chk("rst/err",   32'(err),       32'd0);
    chk("rst/mrd",   32'(mem_read),  32'd0);
    chk("rst/mwr",   32'(mem_write), 32'd0);
    chk("rst/rdata", rdata,          32'h0);
    chk("rst/maddr", mem_addr,       32'h0);
    chk("rst/mwd",   mem_wdata,      32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads from big-endian lanes
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    check_txn("ldb13", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'hFFFF_FFF6);
    chk("ldb13/maddr", t_first_addr, 32'd4);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
    check_txn("ldh10z", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'h0000_8123);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    check_txn("ldh10s", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'hFFFF_8123);

    // Sub-word stores via read-modify-write; rdata must not move
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56AA, 0);
    check_txn("stb11", RD_LAT + WR_LAT + 1, RD_LAT, WR_LAT, 1'b0, 32'hFFFF_8123);
    chk("stb11/mwd", t_wd, 32'h81AA_45F6);
    chk("stb11/mem", mem[4], 32'h81AA_45F6);
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 0);
    check_txn("ldw10", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'h81AA_45F6);
    do_req(1'b1, 2'b01, 1'b1, 32'h12, 32'hFFFF_BEEF, 0);
    check_txn("sth12", RD_LAT + WR_LAT + 1, RD_LAT, WR_LAT, 1'b0, 32'h81AA_45F6);
    chk("sth12/mwd", t_wd, 32'h81AA_BEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 0);
    check_txn("ldb12z", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'h0000_00BE);
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 0);
    check_txn("ldb10s", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'hFFFF_FF81);

    // Range edge and error cases
    do_req(1'b1, 2'b10, 1'b0, 32'h0FFC, 32'hDEAD_BEEF, 0);
    check_txn("stw_top", WR_LAT + 1, 0, WR_LAT, 1'b0, 32'hFFFF_FF81);
    chk("stw_top/mwd", t_wd, 32'hDEAD_BEEF);
    chk("stw_top/mem", mem[1023], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0);
    check_txn("e_range", 1, 0, 0, 1'b1, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 0);
    check_txn("e_half", 1, 0, 0, 1'b1, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    check_txn("e_size", 1, 0, 0, 1'b1, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h1111_1111, 0);
    check_txn("e_word", 1, 0, 0, 1'b1, 32'h0);
    chk("e_word/mem", mem[4], 32'h81AA_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h0FFC, 32'h0, 0);
    check_txn("ldw_top", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'hDEAD_BEEF);

    // Reset in the write phase of a byte store
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h20; wdata = 32'h77;
    wait_n = 0;
    @(negedge clk);
    req = 1'b0;
    while (!mem_write && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("rstwr/reach", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwr/mwr",  32'(mem_write), 32'd0);
    chk("rstwr/busy", 32'(busy),      32'd0);
    chk("rstwr/done", 32'(done),      32'd0);
    idle_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy || mem_write) idle_cnt++;
    end
    chk("rstwr/quiet", 32'(idle_cnt), 32'd0);
    chk("rstwr/mem",   mem[8], 32'h0A0B_0C0D);
    rst_n = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
    check_txn("post_rst", RD_LAT + 1, RD_LAT, 0, 1'b0, 32'h0A0B_0C0D);

    // Inputs toggling while busy must not disturb the access
    do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_0055, 1);
    check_txn("noise", RD_LAT + WR_LAT + 1, RD_LAT, WR_LAT, 1'b0, 32'h0A0B_0C0D);
    chk("noise/mwd", t_wd, 32'h0A0B_0C55);
    chk("noise/mem", mem[8], 32'h0A0B_0C55);

    // req held high: one idle cycle between successive accesses
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0;
    nd = 0; idle_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done && nd < 8) begin
        dpos[nd] = i;
        nd++;
      end
      if (!busy && nd > 0) idle_cnt++;
      if (i == 20) req = 1'b0;
    end
    chk("b2b/ndone", 32'(nd), 32'd5);
    for (int j = 1; j < nd; j++) chk("b2b/gap", 32'(dpos[j] - dpos[j-1]), 32'(RD_LAT + 2));
    chk("b2b/idle",  32'(idle_cnt), 32'(nd));
    chk("b2b/rdata", rdata, 32'h81AA_BEEF);
    wait_n = 0;
    while (busy && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("b2b/drain", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
